imem_responder: RTL and testbench

- Dual-read instruction memory responder; the memory-side end of the fetch unit's imem interface.
- Accepts a read enable plus two word addresses per cycle.
- Returns both instruction words after a fixed, parameterised pipeline latency with a single rvalid.
- Includes a program-load write port and a LOAD/READY state machine so benches and the SoC top can preload code before fetch starts.

---
 rtl/imem_responder.sv | 140 ++++++++++++++
 tb/tb_imem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Dual-read instruction memory responder with a fixed-latency
//            read pipeline, flush, a program-load write port and a
//            LOAD/READY state machine gating reads until code is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     DEPTH_WORDS = 1024,
  parameter int                     LATENCY     = 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'hD503201F
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           imem_ren_i,
  input  logic [ADDR_WIDTH-1:0]          imem_addr0_i,
  input  logic [ADDR_WIDTH-1:0]          imem_addr1_i,
  output logic [INSTR_WIDTH-1:0]         imem_rdata0_o,
  output logic [INSTR_WIDTH-1:0]         imem_rdata1_o,
  output logic                           imem_rvalid_o,
  input  logic                           flush_i,
  input  logic                           prog_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr_i,
  input  logic [INSTR_WIDTH-1:0]         prog_data_i,
  input  logic                           prog_done_i,
  output logic                           ready_o,
  output logic                           err_misalign_o
);

  localparam int                    c_IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-3:0] c_DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  typedef enum logic [0:0] {
    S_LOAD  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_ready;
  logic                     w_accept;

  logic [INSTR_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-3:0]    w_idx0;
  logic [ADDR_WIDTH-3:0]    w_idx1;
  logic                     w_mis0;
  logic                     w_mis1;
  logic [INSTR_WIDTH-1:0]   w_slot0;
  logic [INSTR_WIDTH-1:0]   w_slot1;

  logic [LATENCY-1:0]       r_vld;
  logic [INSTR_WIDTH-1:0]   r_d0 [LATENCY];
  logic [INSTR_WIDTH-1:0]   r_d1 [LATENCY];
  logic [LATENCY-1:0]       w_vin;
  logic [INSTR_WIDTH-1:0]   w_din0 [LATENCY];
  logic [INSTR_WIDTH-1:0]   w_din1 [LATENCY];

  logic                     r_err;

  // State register: LOAD after reset, READY once loading is declared done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_LOAD;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; READY is terminal until reset
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_LOAD:  if (prog_done_i) w_state_nxt = S_READY;
      S_READY: w_ready = 1'b1;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign w_accept = imem_ren_i & w_ready & ~flush_i;

  // Program-load write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (prog_we_i) r_mem[prog_addr_i] <= prog_data_i;
  end

  assign w_idx0  = imem_addr0_i[ADDR_WIDTH-1:2];
  assign w_idx1  = imem_addr1_i[ADDR_WIDTH-1:2];
  assign w_mis0  = |imem_addr0_i[1:0];
  assign w_mis1  = |imem_addr1_i[1:0];
  // Reading the array before the write edge lands gives old data on a collision
  assign w_slot0 = (w_mis0 || (w_idx0 >= c_DEPTH_IDX)) ? NOP_INSTR : r_mem[w_idx0[c_IDX_W-1:0]];
  assign w_slot1 = (w_mis1 || (w_idx1 >= c_DEPTH_IDX)) ? NOP_INSTR : r_mem[w_idx1[c_IDX_W-1:0]];

  // Stage inputs: stage 0 takes the fresh lookup, later stages take their predecessor
  always_comb begin
    w_vin[0]  = w_accept;
    w_din0[0] = w_slot0;
    w_din1[0] = w_slot1;
    for (int i = 1; i < LATENCY; i++) begin
      w_vin[i]  = r_vld[i-1];
      w_din0[i] = r_d0[i-1];
      w_din1[i] = r_d1[i-1];
    end
  end

  // Read pipeline; data only advances with a live unflushed beat so the last stage holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_d0[i] <= '0;
        r_d1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= w_vin[i] & ~flush_i;
        if (w_vin[i] && !flush_i) begin
          r_d0[i] <= w_din0[i];
          r_d1[i] <= w_din1[i];
        end
      end
    end
  end

  // Sticky misalignment flag, set only by accepted reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        r_err <= 1'b0;
    else if (w_accept && (w_mis0 || w_mis1)) r_err <= 1'b1;
  end

  assign imem_rvalid_o  = r_vld[LATENCY-1];
  assign imem_rdata0_o  = r_d0[LATENCY-1];
  assign imem_rdata1_o  = r_d1[LATENCY-1];
  assign ready_o        = w_ready;
  assign err_misalign_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Purpose  : Self-checking bench for imem_responder using a queue-based
//            reference model of memory, latency, flush and LOAD/READY rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int          LAT   = 3;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'hD503201F;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ren, flush, we, done;
  logic [31:0] a0, a1, pd;
  logic [9:0]  pa;
  logic [31:0] rdata0, rdata1;
  logic        rvalid, ready, err;

  imem_responder #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_ren_i(ren), .imem_addr0_i(a0), .imem_addr1_i(a1),
    .imem_rdata0_o(rdata0), .imem_rdata1_o(rdata1), .imem_rvalid_o(rvalid),
    .flush_i(flush), .prog_we_i(we), .prog_addr_i(pa), .prog_data_i(pd),
    .prog_done_i(done), .ready_o(ready), .err_misalign_o(err)
  );

  always #5 clk_i = ~clk_i;

  // Reference model
  typedef struct { int due; logic [31:0] d0; logic [31:0] d1; } resp_t;
  logic [31:0] m_mem [DEPTH];
  resp_t       q[$];
  bit          m_ready, m_err;
  logic [31:0] m_last0, m_last1;
  int          edge_n;
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mslot(input logic [31:0] a);
    if ((a % 4) != 0 || (a / 4) >= DEPTH) return NOP;
    return m_mem[a / 4];
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, DEPTH-1) * 4) + $urandom_range(1, 3);
    if (r == 1) return $urandom_range(DEPTH, 3*DEPTH) * 4;
    return $urandom_range(0, DEPTH-1) * 4;
  endfunction

  task automatic check_outputs();
    bit exp_v;
    exp_v = (q.size() > 0) && (q[0].due == edge_n);
    chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v});
    if (exp_v) begin
      m_last0 = q[0].d0;
      m_last1 = q[0].d1;
      void'(q.pop_front());
    end
    chk("rdata0", rdata0, m_last0);
    chk("rdata1", rdata1, m_last1);
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    chk("err_misalign", {31'b0, err}, {31'b0, m_err});
  endtask

  // One clock: apply the model's view of this edge, then check just after it
  task automatic step();
    @(posedge clk_i);
    edge_n++;
    if (flush) q.delete();
    else if (ren && m_ready) begin
      q.push_back('{edge_n + LAT - 1, mslot(a0), mslot(a1)});
      if ((a0 % 4) != 0 || (a1 % 4) != 0) m_err = 1'b1;
    end
    if (we) m_mem[pa] = pd;
    if (done) m_ready = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic cyc(input logic r, input logic [31:0] x0, input logic [31:0] x1,
                     input logic f, input logic w, input logic [9:0] wa,
                     input logic [31:0] wd, input logic dn);
    ren = r; a0 = x0; a1 = x1; flush = f; we = w; pa = wa; pd = wd; done = dn;
    step();
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_last0 = '0;
    m_last1 = '0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; edge_n = 0;
    model_reset();
    rst_ni = 1'b0;
    ren = 0; a0 = 0; a1 = 0; flush = 0; we = 0; pa = 0; pd = 0; done = 0;
    #3;
    chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    #9 rst_ni = 1'b1;

    // Load every word; random reads while in LOAD must never respond
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      case (i)
        0: d = 32'h11111111;
        1: d = 32'h22222222;
        2: d = 32'h33333333;
        3: d = 32'h44444444;
        5: d = 32'h55555555;
        default: d = $urandom;
      endcase
      cyc($urandom_range(0, 1) == 1, 32'h0, rand_addr(), 0, 1, 10'(i), d, 0);
    end
    for (int i = 0; i < 6; i++) cyc(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);

    // prog_done together with a read: read ignored, READY next cycle
    cyc(1, 32'h0, 32'h4, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back reads come out in order on consecutive cycles
    for (int i = 0; i < 4; i++) cyc(1, 32'(i*8), 32'(i*8 + 4), 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Misaligned slot 0 and out-of-range slot 1 both give NOP; flag sticks
    cyc(1, 32'h2, 32'(DEPTH*4), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h8, 32'hC, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Flush kills an in-flight read; a read right after flush proceeds
    cyc(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 32'h10, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write and read of word 5 returns the old value
    cyc(1, 32'h14, 32'h14, 0, 1, 10'd5, 32'hAAAAAAAA, 0);
    cyc(1, 32'h14, 32'h10, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomised mix of reads, writes, flushes
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_addr(), rand_addr(),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          10'($urandom_range(0, DEPTH-1)), $urandom, $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset in the middle of a read stream
    for (int i = 0; i < LAT; i++) cyc(1, 32'(i*4), 32'(i*4 + 4), 0, 0, 0, 0, 0);
    ren = 0; flush = 0; we = 0; done = 0;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    chk("midrst_rdata0", rdata0, 32'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < LAT + 2; i++) cyc(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h0, 32'h14, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
